// File: rtl/l2_refill_responder_if.sv
// ---------------------------------------------------------------------------
// l2_refill_responder_if
//   Bundles the L1 request side, the response side and the backing-memory
//   handshake of the L2 refill responder.
//
//   L1 requests (per thread, level-sensitive):
//     req_refill, req_spec, br_req    NUM_THREADS bits each
//     fetch_addr, br_addr             32 bits per thread, thread t at [t*32 +: 32]
//   Response (registered, one-cycle strobe):
//     l2_cache_block_rsp (128), PC_L2_o (32), tid_to_l1 (TID_BITS), rsp_valid
//   Status:
//     busy                            high while a transaction is in flight
//   Backing memory:
//     mem_req/mem_addr (out), mem_gnt/mem_rvalid/mem_rdata (in)
//
//   Modports: slave = responder side, master = L1/memory environment side.
// ---------------------------------------------------------------------------
interface l2_refill_responder_if #(
  parameter int NUM_THREADS = 4
);
  localparam int TID_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [NUM_THREADS-1:0]    req_refill;
  logic [NUM_THREADS-1:0]    req_spec;
  logic [NUM_THREADS-1:0]    br_req;
  logic [NUM_THREADS*32-1:0] fetch_addr;
  logic [NUM_THREADS*32-1:0] br_addr;

  logic [127:0]              l2_cache_block_rsp;
  logic [31:0]               PC_L2_o;
  logic [TID_BITS-1:0]       tid_to_l1;
  logic                      rsp_valid;
  logic                      busy;

  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [127:0]              mem_rdata;

  modport slave (
    input  req_refill, req_spec, br_req, fetch_addr, br_addr,
    output l2_cache_block_rsp, PC_L2_o, tid_to_l1, rsp_valid, busy,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_refill, req_spec, br_req, fetch_addr, br_addr,
    input  l2_cache_block_rsp, PC_L2_o, tid_to_l1, rsp_valid, busy,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/l2_refill_responder.sv
// ---------------------------------------------------------------------------
// l2_refill_responder
//   L2-side responder for the per-thread L1 instruction buffers. Each thread
//   presents at most one candidate (branch > refill > speculative prefetch);
//   one candidate is picked round-robin per transaction and answered either
//   from a one-line local buffer or from backing memory. One transaction is
//   outstanding at a time.
//
//   Ports:
//     clk    clock, all state on posedge
//     reset  asynchronous reset, active-low
//     bus    l2_refill_responder_if.slave (requests, response, memory bus)
// ---------------------------------------------------------------------------
module l2_refill_responder #(
  parameter int NUM_THREADS = 4,
  parameter int LINE_BYTES  = 16
) (
  input logic                        clk,
  input logic                        reset,
  l2_refill_responder_if.slave       bus
);

  localparam int TID_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [31:0] LINE_STEP = 32'(LINE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_MEM_REQ, ST_MEM_WAIT, ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    KIND_BR, KIND_REFILL, KIND_SPEC
  } kind_t;

  // Transaction state
  state_t              state_q;
  logic [TID_BITS-1:0] rr_ptr_q;
  logic [TID_BITS-1:0] tid_q;
  kind_t               kind_q;
  logic [31:0]         addr_q;

  // One-line local buffer
  logic                buf_valid_q;
  logic [31:0]         buf_addr_q;
  logic [127:0]        buf_data_q;

  // Last speculative line served per thread, used to drop repeat prefetches
  logic [NUM_THREADS-1:0] spec_last_valid_q;
  logic [31:0]            spec_last_addr_q [NUM_THREADS];

  // Registered outputs
  logic                rsp_valid_q;
  logic [127:0]        rsp_data_q;
  logic [31:0]         rsp_addr_q;
  logic [TID_BITS-1:0] rsp_tid_q;
  logic                mem_req_q;
  logic [31:0]         mem_addr_q;

  // Per-thread candidate selection
  logic [NUM_THREADS-1:0] cand_valid;
  kind_t                  cand_kind [NUM_THREADS];
  logic [31:0]            cand_addr [NUM_THREADS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_cand
      logic [31:0] br_line;
      logic [31:0] refill_line;
      logic [31:0] spec_line;
      logic        spec_dup;

      assign br_line     = bus.br_addr[gi*32 +: 32] & LINE_MASK;
      assign refill_line = bus.fetch_addr[gi*32 +: 32] & LINE_MASK;
      // Low offset bits are zero, so a plain 32-bit add wraps the block
      // address exactly like a 28-bit increment.
      assign spec_line   = refill_line + LINE_STEP;
      assign spec_dup    = spec_last_valid_q[gi] && (spec_last_addr_q[gi] == spec_line);

      assign cand_valid[gi] = bus.br_req[gi] | bus.req_refill[gi] |
                              (bus.req_spec[gi] & ~spec_dup);
      assign cand_kind[gi]  = bus.br_req[gi]     ? KIND_BR :
                              bus.req_refill[gi] ? KIND_REFILL : KIND_SPEC;
      assign cand_addr[gi]  = bus.br_req[gi]     ? br_line :
                              bus.req_refill[gi] ? refill_line : spec_line;
    end
  endgenerate

  // Round-robin scan starting at rr_ptr_q; thread count is a power of two so
  // the index wraps naturally.
  logic                win_found;
  logic [TID_BITS-1:0] win_tid;
  logic [TID_BITS-1:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_tid   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      scan_idx = rr_ptr_q + TID_BITS'(i);
      if (!win_found && cand_valid[scan_idx]) begin
        win_found = 1'b1;
        win_tid   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      rr_ptr_q          <= '0;
      tid_q             <= '0;
      kind_q            <= KIND_BR;
      addr_q            <= '0;
      buf_valid_q       <= 1'b0;
      buf_addr_q        <= '0;
      buf_data_q        <= '0;
      spec_last_valid_q <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        spec_last_addr_q[t] <= '0;
      end
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
      rsp_addr_q        <= '0;
      rsp_tid_q         <= '0;
      mem_req_q         <= 1'b0;
      mem_addr_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            tid_q    <= win_tid;
            kind_q   <= cand_kind[win_tid];
            addr_q   <= cand_addr[win_tid];
            rr_ptr_q <= win_tid + TID_BITS'(1);
            state_q  <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (buf_valid_q && (buf_addr_q == addr_q)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= buf_data_q;
            rsp_addr_q  <= addr_q;
            rsp_tid_q   <= tid_q;
            state_q     <= ST_RESP;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= addr_q;
            state_q    <= ST_MEM_REQ;
          end
        end

        ST_MEM_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_MEM_WAIT;
          end
        end

        ST_MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            buf_data_q  <= bus.mem_rdata;
            buf_addr_q  <= addr_q;
            buf_valid_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mem_rdata;
            rsp_addr_q  <= addr_q;
            rsp_tid_q   <= tid_q;
            state_q     <= ST_RESP;
          end
        end

        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          // A demand fetch moves the thread's stream, so re-arm its prefetch.
          if (kind_q == KIND_SPEC) begin
            spec_last_addr_q[tid_q]  <= addr_q;
            spec_last_valid_q[tid_q] <= 1'b1;
          end else begin
            spec_last_valid_q[tid_q] <= 1'b0;
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.l2_cache_block_rsp = rsp_data_q;
  assign bus.PC_L2_o            = rsp_addr_q;
  assign bus.tid_to_l1          = rsp_tid_q;
  assign bus.busy               = (state_q != ST_IDLE);
  assign bus.mem_req            = mem_req_q;
  assign bus.mem_addr           = mem_addr_q;

endmodule

// File: tb/tb_l2_refill_responder.sv
module tb_l2_refill_responder;

  localparam int K_BR = 0, K_REF = 1, K_SPEC = 2;

  logic clk;
  logic reset;

  l2_refill_responder_if #(.NUM_THREADS(4)) bus();

  l2_refill_responder #(.NUM_THREADS(4), .LINE_BYTES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   tid;
    logic [31:0]  pc;
    logic [127:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int          tid;
    int          kind;
    logic [31:0] addr;
    logic [31:0] pc;
    int          lat;
    int          mem;
  } vec_t;
  vec_t vecs [7];

  // Memory model controls
  bit          hold_gnt      = 1'b0;
  bit          hold_rvalid   = 1'b0;
  bit          inject_rvalid = 1'b0;
  int          mem_txn_count = 0;
  logic [31:0] last_grant_addr = '0;
  bit          rv_pending = 1'b0;
  logic [31:0] rv_addr = '0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, a ^ 32'h0000_5A5A, ~a, a + 32'h1111_1111};
  endfunction

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int t, input logic [31:0] pc);
    exp_t e;
    e.tid  = 2'(t);
    e.pc   = pc;
    e.data = line_of(pc);
    sb.push_back(e);
  endtask

  task automatic set_req(input int t, input int kind, input logic [31:0] a, input logic lvl);
    case (kind)
      K_BR: begin
        bus.br_req[t] = lvl;
        if (lvl) bus.br_addr[t*32 +: 32] = a;
      end
      K_REF: begin
        bus.req_refill[t] = lvl;
        if (lvl) bus.fetch_addr[t*32 +: 32] = a;
      end
      default: begin
        bus.req_spec[t] = lvl;
        if (lvl) bus.fetch_addr[t*32 +: 32] = a;
      end
    endcase
  endtask

  // Latency = number of falling edges after the call until rsp_valid is seen.
  task automatic wait_rsp(input string name, output int lat, output bit ok);
    lat = -1;
    ok  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no rsp_valid in 60 cycles, required a response", name);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit ok;
    int m0;
    m0 = mem_txn_count;
    set_req(v.tid, v.kind, v.addr, 1'b1);
    push_exp(v.tid, v.pc);
    wait_rsp(tag, lat, ok);
    set_req(v.tid, v.kind, v.addr, 1'b0);
    if (ok) check_int({tag, "_lat"}, lat, v.lat);
    check_int({tag, "_memtxn"}, mem_txn_count - m0, v.mem);
    if (v.mem != 0) check_vec({tag, "_maddr"}, 128'(last_grant_addr), 128'(v.pc));
    @(negedge clk);
    check_vec({tag, "_busy_after"}, 128'(bus.busy), 128'(0));
    $display("[TB] %s tid=%0d kind=%0d addr=%h -> pc=%h lat=%0d", tag, v.tid, v.kind, v.addr, v.pc, lat);
  endtask

  // Backing memory: acts just after each rising edge, grants when allowed,
  // returns the line on the following cycle unless held off.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!reset) begin
        rv_pending = 1'b0;
      end else if (rv_pending) begin
        if (!hold_rvalid) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = line_of(rv_addr);
          rv_pending     = 1'b0;
        end
      end else if (inject_rvalid) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = '1;
      end else if (bus.mem_req === 1'b1 && !hold_gnt) begin
        bus.mem_gnt     = 1'b1;
        rv_pending      = 1'b1;
        rv_addr         = bus.mem_addr;
        last_grant_addr = bus.mem_addr;
        mem_txn_count++;
      end
    end
  end

  // Response scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got tid=%0d pc=%h, required no response", bus.tid_to_l1, bus.PC_L2_o);
        end else begin
          mon_e = sb.pop_front();
          check_vec("rsp_tid", 128'(bus.tid_to_l1), 128'(mon_e.tid));
          check_vec("rsp_pc", 128'(bus.PC_L2_o), 128'(mon_e.pc));
          check_vec("rsp_line", bus.l2_cache_block_rsp, mon_e.data);
          $display("[TB] rsp tid=%0d pc=%h", bus.tid_to_l1, bus.PC_L2_o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit ok;
    int m0;
    int cnt;

    vecs[0] = '{1, K_REF,  32'h0000_1234, 32'h0000_1230, 4, 1};
    vecs[1] = '{2, K_REF,  32'h0000_123C, 32'h0000_1230, 2, 0};
    vecs[2] = '{0, K_BR,   32'h0000_5678, 32'h0000_5670, 4, 1};
    vecs[3] = '{3, K_REF,  32'h0000_5674, 32'h0000_5670, 2, 0};
    vecs[4] = '{1, K_SPEC, 32'hFFFF_FFFC, 32'h0000_0000, 4, 1};
    vecs[5] = '{2, K_SPEC, 32'h0000_0008, 32'h0000_0010, 4, 1};
    vecs[6] = '{3, K_BR,   32'h0000_123F, 32'h0000_1230, 4, 1};

    bus.req_refill = '0;
    bus.req_spec   = '0;
    bus.br_req     = '0;
    bus.fetch_addr = '0;
    bus.br_addr    = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("reset_line", bus.l2_cache_block_rsp, 128'(0));
    check_vec("reset_ctl", 128'({bus.rsp_valid, bus.busy, bus.mem_req, bus.tid_to_l1, bus.PC_L2_o, bus.mem_addr}), 128'(0));
    $display("[TB] reset state checked");
    reset = 1'b1;
    @(negedge clk);

    // Table: misses, buffer hits, branch, spec with address wrap
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Priority within a thread and round-robin across threads (rr_ptr is 0)
    set_req(0, K_BR,  32'h0000_0200, 1'b1);
    set_req(0, K_REF, 32'h0000_0100, 1'b1);
    set_req(3, K_REF, 32'h0000_0300, 1'b1);
    push_exp(0, 32'h0000_0200);
    push_exp(3, 32'h0000_0300);
    push_exp(0, 32'h0000_0100);
    wait_rsp("prio1", lat, ok);
    set_req(0, K_BR, 32'h0, 1'b0);
    wait_rsp("prio2", lat, ok);
    set_req(3, K_REF, 32'h0, 1'b0);
    wait_rsp("prio3", lat, ok);
    set_req(0, K_REF, 32'h0, 1'b0);
    @(negedge clk);
    check_int("prio_queue_drained", sb.size(), 0);
    $display("[TB] priority/round-robin sequence done");

    // Held spec on thread 1 repeats the line already prefetched: suppressed
    m0 = mem_txn_count;
    set_req(1, K_SPEC, 32'hFFFF_FFFC, 1'b1);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
    end
    check_int("spec_dedup_busy", cnt, 0);
    // A refill re-arms spec, so the held spec level is served once more
    push_exp(1, 32'hFFFF_FFF0);
    push_exp(1, 32'h0000_0000);
    set_req(1, K_REF, 32'hFFFF_FFFC, 1'b1);
    wait_rsp("rearm_refill", lat, ok);
    set_req(1, K_REF, 32'h0, 1'b0);
    wait_rsp("rearm_spec", lat, ok);
    repeat (8) @(negedge clk);
    set_req(1, K_SPEC, 32'h0, 1'b0);
    check_int("rearm_memtxn", mem_txn_count - m0, 2);
    $display("[TB] spec dedup and re-arm sequence done");

    // Memory backpressure with a stray rvalid while waiting for grant
    m0 = mem_txn_count;
    hold_gnt = 1'b1;
    set_req(2, K_REF, 32'h0000_4008, 1'b1);
    push_exp(2, 32'h0000_4000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) break;
    end
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h0000_4000) cnt++;
      if (c == 1) inject_rvalid = 1'b1;
      if (c == 2) inject_rvalid = 1'b0;
      @(negedge clk);
    end
    check_int("bp_stable_cycles", cnt, 5);
    hold_gnt = 1'b0;
    wait_rsp("bp", lat, ok);
    set_req(2, K_REF, 32'h0, 1'b0);
    check_int("bp_memtxn", mem_txn_count - m0, 1);
    @(negedge clk);
    $display("[TB] backpressure sequence done");

    // Reset while waiting for read data
    m0 = mem_txn_count;
    hold_rvalid = 1'b1;
    set_req(1, K_REF, 32'h0000_7004, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_txn_count != m0) break;
    end
    check_int("rst_reached_wait", mem_txn_count - m0, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_vec("rst_mid_line", bus.l2_cache_block_rsp, 128'(0));
    check_vec("rst_mid_ctl", 128'({bus.rsp_valid, bus.busy, bus.mem_req, bus.tid_to_l1, bus.PC_L2_o, bus.mem_addr}), 128'(0));
    hold_rvalid = 1'b0;
    // Line 0x4000 sat in the buffer before reset; it must now come from memory
    set_req(0, K_REF, 32'h0000_4000, 1'b1);
    repeat (2) @(negedge clk);
    m0 = mem_txn_count;
    reset = 1'b1;
    push_exp(0, 32'h0000_4000);
    push_exp(1, 32'h0000_7000);
    wait_rsp("post_rst1", lat, ok);
    set_req(0, K_REF, 32'h0, 1'b0);
    if (ok) check_int("post_rst1_lat", lat, 4);
    wait_rsp("post_rst2", lat, ok);
    set_req(1, K_REF, 32'h0, 1'b0);
    check_int("post_rst_memtxn", mem_txn_count - m0, 2);
    $display("[TB] reset mid-transaction sequence done");

    repeat (10) @(negedge clk);
    check_int("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
